cache_arbiter: RTL and testbench

Two-requester arbiter that shares the single cache-line physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core. Sits between the I-cache and D-cache and the memory port. Serializes one line transfer at a time with a registered memory-side request. Breaks ties between simultaneous requesters by alternating grant.

---
 rtl/cache_arbiter.sv | 102 ++++++++++
 tb/tb_cache_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cache-line memory port between the I-cache fill
// path and the D-cache fill/writeback path. One transfer is in flight at a
// time. The memory-side request is registered. Ties alternate between the
// two sides, and a one-cycle recovery slot follows every completion.
module cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;
   localparam logic [1:0] RECOVER = 2'd3;

   // Clears the byte offset within a line so the memory only sees line addresses.
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

   logic [1:0] state;
   logic       last_grant;   // 1 = D side was granted most recently
   logic       d_req;
   logic       grant_i;
   logic       grant_d;

   // Grant decision in IDLE; a tie goes to the side not granted last time.
   always_comb begin
      d_req   = d_read | d_write;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         grant_i = i_read & (~d_req | last_grant);
         grant_d = d_req & (~i_read | ~last_grant);
      end
   end

   // Fill data is a plain pass-through; only the resp pulses qualify it.
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;
   assign i_resp  = (state == SERVE_I) & pmem_resp;
   assign d_resp  = (state == SERVE_D) & pmem_resp;

   // Transfer FSM and registered memory-side request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  state      <= SERVE_I;
                  last_grant <= 1'b0;
                  pmem_read  <= 1'b1;
                  pmem_write <= 1'b0;
                  pmem_addr  <= i_addr & LINE_MASK;
                  pmem_wdata <= d_wdata;
               end else if (grant_d) begin
                  // A simultaneous read+write is illegal; the write wins.
                  state      <= SERVE_D;
                  last_grant <= 1'b1;
                  pmem_read  <= d_read & ~d_write;
                  pmem_write <= d_write;
                  pmem_addr  <= d_addr & LINE_MASK;
                  pmem_wdata <= d_wdata;
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state      <= RECOVER;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end
            end
            RECOVER: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: drives line requests into cache_arbiter. It plays the
// memory side. Each expected grant is queued when the request is driven and
// checked when the arbiter raises its memory request.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_read = 1'b0;
   logic [31:0]  i_addr = '0;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [31:0]  d_addr = '0;
   logic [255:0] d_wdata = '0;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_addr;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   cache_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         side_d;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wd;
   } exp_t;

   typedef struct {
      logic         ir;
      logic         dr;
      logic         dw;
      logic [31:0]  addr;
      logic [255:0] wd;
      int           lat;
      logic [255:0] rd;
      logic         perturb;
      logic         exp_d;
      logic         exp_wr;
      logic [31:0]  exp_addr;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[4];
   int   n_cmp = 0;
   int   n_err = 0;
   int   gap;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic push(input logic side_d, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wd);
      exp_t e;
      e.side_d = side_d; e.wr = wr; e.addr = addr; e.wd = wd;
      exp_q.push_back(e);
   endtask

   // Waits for a memory request, checks it against the scoreboard, holds it
   // for lat cycles counted from the request cycle, then returns rd with a
   // pmem_resp pulse. Returns at the negedge of the recovery cycle.
   task automatic serve(input int lat, input logic [255:0] rd, input logic drop_i,
                        input logic drop_d, input logic perturb, output int gap_o);
      exp_t         e;
      int           n = 0;
      logic [31:0]  a0;
      logic [255:0] w0;
      gap_o = 0;
      @(negedge clk);
      while (!(pmem_read || pmem_write) && n < 60) begin
         @(negedge clk);
         n++;
      end
      gap_o = n;
      if (!(pmem_read || pmem_write)) begin
         n_cmp++; n_err++;
         $display("FAIL req_timeout: got no pmem request required one within 60 cycles");
         return;
      end
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard: got unexpected request addr %h required none", pmem_addr);
         return;
      end
      e = exp_q.pop_front();
      check("pmem_write", 256'(pmem_write), 256'(e.wr));
      check("pmem_read", 256'(pmem_read), 256'(!e.wr));
      check("pmem_addr", 256'(pmem_addr), 256'(e.addr));
      if (e.wr) check("pmem_wdata", pmem_wdata, e.wd);
      a0 = pmem_addr;
      w0 = pmem_wdata;
      for (int k = 0; k < lat - 2; k++) begin
         if (perturb && k == 0) begin
            d_addr  = ~d_addr;
            d_wdata = ~d_wdata;
         end
         @(negedge clk);
         check("hold_addr", 256'(pmem_addr), 256'(a0));
         check("hold_req", 256'({pmem_read, pmem_write}), 256'({!e.wr, e.wr}));
         if (e.wr) check("hold_wdata", pmem_wdata, w0);
         check("early_resp", 256'({i_resp, d_resp}), 256'(0));
      end
      @(posedge clk); #1;
      pmem_resp  = 1'b1;
      pmem_rdata = rd;
      @(negedge clk);
      check("resp_sides", 256'({i_resp, d_resp}), 256'({!e.side_d, e.side_d}));
      check("rdata", e.side_d ? d_rdata : i_rdata, rd);
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (drop_i) i_read = 1'b0;
      if (drop_d) begin d_read = 1'b0; d_write = 1'b0; end
      @(negedge clk);
      check("recover_req", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "global timeout");
   end

   initial begin
      tbl[0] = '{ir:1, dr:0, dw:0, addr:32'h0000_1234, wd:'0, lat:4, rd:{32{8'hA5}},
                 perturb:0, exp_d:0, exp_wr:0, exp_addr:32'h0000_1220};
      tbl[1] = '{ir:0, dr:1, dw:0, addr:32'h0000_0FFF, wd:'0, lat:2, rd:{8{32'hDEAD_BEEF}},
                 perturb:0, exp_d:1, exp_wr:0, exp_addr:32'h0000_0FE0};
      tbl[2] = '{ir:0, dr:0, dw:1, addr:32'h8000_003F, wd:{8{32'h1122_33FF}}, lat:5, rd:'0,
                 perturb:1, exp_d:1, exp_wr:1, exp_addr:32'h8000_0020};
      tbl[3] = '{ir:1, dr:0, dw:0, addr:32'hFFFF_FFFF, wd:'0, lat:6, rd:{16{16'h5A3C}},
                 perturb:0, exp_d:0, exp_wr:0, exp_addr:32'hFFFF_FFE0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));
      check("reset_addr", 256'(pmem_addr), 256'(0));
      rst_n = 1'b1;

      // Tie after reset goes to I, then D three cycles after i_resp
      @(posedge clk); #1;
      i_read = 1'b1; i_addr = 32'h0000_2000;
      d_read = 1'b1; d_addr = 32'h0000_3010;
      push(0, 0, 32'h0000_2000, '0);
      push(1, 0, 32'h0000_3000, '0);
      serve(3, {8{32'h0101_0101}}, 1, 0, 0, gap);
      serve(3, {8{32'h0202_0202}}, 0, 1, 0, gap);
      check("tie_gap", 256'(gap), 256'(1));

      // Repeated ties alternate I, D, I, D
      @(posedge clk); #1;
      i_read = 1'b1; d_read = 1'b1;
      for (int t = 0; t < 4; t++) push(t[0], 0, (t[0] ? 32'h0000_3000 : 32'h0000_2000), '0);
      for (int t = 0; t < 4; t++) begin
         serve(2 + t, {8{32'(t + 16)}}, t == 3, t == 3, 0, gap);
         if (t > 0) check("rep_gap", 256'(gap), 256'(1));
      end

      // Table of single-requester transfers
      for (int v = 0; v < 4; v++) begin
         @(posedge clk); #1;
         if (tbl[v].ir) begin
            i_read = 1'b1; i_addr = tbl[v].addr;
         end else begin
            d_read = tbl[v].dr; d_write = tbl[v].dw;
            d_addr = tbl[v].addr; d_wdata = tbl[v].wd;
         end
         push(tbl[v].exp_d, tbl[v].exp_wr, tbl[v].exp_addr, tbl[v].wd);
         serve(tbl[v].lat, tbl[v].rd, tbl[v].ir, !tbl[v].ir, tbl[v].perturb, gap);
         check("vec_gap", 256'(gap), 256'(1));
      end

      // Spurious pmem_resp in IDLE, then illegal read+write issues as write
      @(posedge clk); #1;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("spurious_resp", 256'({i_resp, d_resp}), 256'(0));
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      check("spurious_req", 256'({pmem_read, pmem_write}), 256'(0));
      d_read = 1'b1; d_write = 1'b1;
      d_addr = 32'h4000_0010; d_wdata = {4{64'h0123_4567_89AB_CDEF}};
      push(1, 1, 32'h4000_0000, {4{64'h0123_4567_89AB_CDEF}});
      serve(3, '0, 0, 1, 0, gap);
      check("illegal_gap", 256'(gap), 256'(1));

      // Reset during SERVE_D abandons the transfer
      @(posedge clk); #1;
      d_write = 1'b1; d_addr = 32'h1000_0040; d_wdata = {8{32'hCAFE_F00D}};
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_write", 256'(pmem_write), 256'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));
      check("async_rst_addr", 256'(pmem_addr), 256'(0));
      d_write = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b1;
      @(negedge clk);
      check("late_resp", 256'({i_resp, d_resp}), 256'(0));
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 256'({pmem_read, pmem_write}), 256'(0));
      @(posedge clk); #1;
      i_read = 1'b1; i_addr = 32'h0000_5555;
      d_read = 1'b1; d_addr = 32'h0000_6666;
      push(0, 0, 32'h0000_5540, '0);
      push(1, 0, 32'h0000_6660, '0);
      serve(2, {8{32'h7777_7777}}, 1, 0, 0, gap);
      serve(2, {8{32'h8888_8888}}, 0, 1, 0, gap);

      check("queue_empty", 256'(exp_q.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
